// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back arbiter and access guard for the 32x32 register file.
// Merges the ALU and load write-back streams onto one registered write
// port. Requests are accepted on valid && ready. When both streams
// request at once, round-robin arbitration picks the one not granted
// last. Writes to x0 are consumed silently. The protected register range
// (secure key/context registers) is writable only for a short window
// after a correct unlock key. Illegal accesses raise a sticky violation
// flag that only reset clears.
//
// Parameters
//   KEY            unlock key compared against unlock_key
//   PROT_LO        lowest protected register index (inclusive)
//   PROT_HI        highest protected register index (inclusive)
//   UNLOCK_WINDOW  cycles the protected range stays writable after unlock (1..255)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/addr/data, alu_ready  ALU write-back request and combinational accept
//   mem_valid/addr/data, mem_ready  load write-back request and combinational accept
//   unlock_req, unlock_key          single-cycle unlock/relock strobe and its key
//   wr_en, wr_addr, wr_data         registered register-file write port
//   locked                          1 while the protected range is write-locked
//   violation                       sticky security violation flag

module regfile_wb_arbiter #(
  parameter logic [15:0] KEY           = 16'h0032,
  parameter logic [4:0]  PROT_LO       = 5'd28,
  parameter logic [4:0]  PROT_HI       = 5'd31,
  parameter int unsigned UNLOCK_WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        unlock_req,
  input  logic [15:0] unlock_key,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        locked,
  output logic        violation
);

  typedef enum logic {
    LOCKED   = 1'b0,
    UNLOCKED = 1'b1
  } lockState_e;

  localparam logic [7:0] WINDOW_LOAD = 8'(UNLOCK_WINDOW);

  lockState_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        lastGrantMem_q, lastGrantMem_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        violation_q, violation_d;

  logic        aluGrant;
  logic        memGrant;
  logic        accept;
  logic [4:0]  selAddr;
  logic [31:0] selData;
  logic        isZero;
  logic        isProt;
  logic        protDrop;
  logic        keyOk;
  logic        badUnlock;

  // Round-robin grant: a lone requester always wins; on conflict the
  // requester that was not granted last wins. Depends only on the valids
  // and the pointer so ready never waits on address decode or lock state.
  always_comb begin
    aluGrant = alu_valid && (!mem_valid || lastGrantMem_q);
    memGrant = mem_valid && (!alu_valid || !lastGrantMem_q);
  end

  assign alu_ready = aluGrant;
  assign mem_ready = memGrant;

  // Decode of the accepted request. Lock decisions use the state before
  // the edge, so a protected write arriving with a valid unlock is still
  // dropped, and one arriving in the final unlocked cycle still lands.
  always_comb begin
    accept    = aluGrant || memGrant;
    selAddr   = memGrant ? mem_addr : alu_addr;
    selData   = memGrant ? mem_data : alu_data;
    isZero    = (selAddr == 5'd0);
    isProt    = (selAddr >= PROT_LO) && (selAddr <= PROT_HI);
    protDrop  = accept && isProt && !isZero && (state_q == LOCKED);
    keyOk     = (unlock_key == KEY);
    badUnlock = unlock_req && !keyOk;
  end

  // Write port and bookkeeping next-state. Address/data hold their last
  // value when no write issues; the pointer only moves on an acceptance.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    lastGrantMem_d = lastGrantMem_q;
    violation_d    = violation_q || protDrop || badUnlock;
    if (accept) begin
      lastGrantMem_d = memGrant;
      if (!isZero && !protDrop) begin
        wr_en_d   = 1'b1;
        wr_addr_d = selAddr;
        wr_data_d = selData;
      end
    end
  end

  // Lock FSM. A correct key reload beats the window countdown; a wrong
  // key while unlocked relocks at once. The window closes on the edge
  // where the counter reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOCKED: begin
        if (unlock_req && keyOk) begin
          state_d = UNLOCKED;
          cnt_d   = WINDOW_LOAD;
        end
      end
      UNLOCKED: begin
        if (unlock_req && keyOk) begin
          cnt_d = WINDOW_LOAD;
        end else if (unlock_req) begin
          state_d = LOCKED;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d = LOCKED;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = LOCKED;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOCKED;
      cnt_q          <= 8'd0;
      lastGrantMem_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 5'd0;
      wr_data_q      <= 32'd0;
      violation_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lastGrantMem_q <= lastGrantMem_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      violation_q    <= violation_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign locked    = (state_q == LOCKED);
  assign violation = violation_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after
// the rising edge; combinational readies are sampled on the falling edge
// and registered outputs 1 time unit after the rising edge.

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rstN;
  logic        aluValid;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        memReady;
  logic        unlockReq;
  logic [15:0] unlockKey;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        locked;
  logic        violation;

  int assertCount = 0;
  int failCount   = 0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rstN),
    .alu_valid  (aluValid),
    .alu_addr   (aluAddr),
    .alu_data   (aluData),
    .alu_ready  (aluReady),
    .mem_valid  (memValid),
    .mem_addr   (memAddr),
    .mem_data   (memData),
    .mem_ready  (memReady),
    .unlock_req (unlockReq),
    .unlock_key (unlockKey),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .locked     (locked),
    .violation  (violation)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic ur, input logic [15:0] uk);
    aluValid  = av;
    aluAddr   = aa;
    aluData   = ad;
    memValid  = mv;
    memAddr   = ma;
    memData   = md;
    unlockReq = ur;
    unlockKey = uk;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    idle();
    #1;
    checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd1);
    checkOutput("rst_violation", 32'(violation), 32'd0);
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    logic expMem;
    logic [31:0] expData;
    logic [4:0]  expAddr;

    rstN = 1'b0;
    idle();

    // Reset state
    #2;
    checkOutput("reset_wr_en", 32'(wrEn), 32'd0);
    checkOutput("reset_wr_addr", 32'(wrAddr), 32'd0);
    checkOutput("reset_wr_data", wrData, 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd1);
    checkOutput("reset_violation", 32'(violation), 32'd0);
    checkOutput("reset_alu_ready", 32'(aluReady), 32'd0);
    checkOutput("reset_mem_ready", 32'(memReady), 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    tick();

    // Single ALU write
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
    midCycle();
    checkOutput("single_alu_ready", 32'(aluReady), 32'd1);
    checkOutput("single_mem_ready", 32'(memReady), 32'd0);
    tick();
    idle();
    checkOutput("single_wr_en", 32'(wrEn), 32'd1);
    checkOutput("single_wr_addr", 32'(wrAddr), 32'd5);
    checkOutput("single_wr_data", wrData, 32'hDEAD_BEEF);
    checkOutput("single_mem_ready_after", 32'(memReady), 32'd0);

    // Sustained conflict: last grant was ALU, so MEM wins first
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd3, 32'hA000_0000 + 32'(i),
                    1'b1, 5'd4, 32'hB000_0000 + 32'(i), 1'b0, 16'd0);
      expMem  = (i % 2 == 0);
      expAddr = expMem ? 5'd4 : 5'd3;
      expData = expMem ? (32'hB000_0000 + 32'(i)) : (32'hA000_0000 + 32'(i));
      midCycle();
      checkOutput($sformatf("conflict%0d_mem_ready", i), 32'(memReady), 32'(expMem));
      checkOutput($sformatf("conflict%0d_alu_ready", i), 32'(aluReady), 32'(!expMem));
      tick();
      checkOutput($sformatf("conflict%0d_wr_en", i), 32'(wrEn), 32'd1);
      checkOutput($sformatf("conflict%0d_wr_addr", i), 32'(wrAddr), 32'(expAddr));
      checkOutput($sformatf("conflict%0d_wr_data", i), wrData, expData);
    end
    idle();
    tick();
    checkOutput("idle_wr_en", 32'(wrEn), 32'd0);
    checkOutput("idle_wr_addr_hold", 32'(wrAddr), 32'd3);
    checkOutput("idle_wr_data_hold", wrData, 32'hA000_0003);

    // x0 drop
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 16'd0);
    midCycle();
    checkOutput("x0_mem_ready", 32'(memReady), 32'd1);
    tick();
    idle();
    checkOutput("x0_wr_en", 32'(wrEn), 32'd0);
    checkOutput("x0_violation", 32'(violation), 32'd0);
    checkOutput("x0_wr_addr_hold", 32'(wrAddr), 32'd3);

    // Locked protected write
    applyStimulus(1'b1, 5'd30, 32'hCAFE_0030, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
    midCycle();
    checkOutput("prot_alu_ready", 32'(aluReady), 32'd1);
    tick();
    idle();
    checkOutput("prot_wr_en", 32'(wrEn), 32'd0);
    checkOutput("prot_violation", 32'(violation), 32'd1);
    tick();
    tick();
    checkOutput("prot_violation_sticky", 32'(violation), 32'd1);
    checkOutput("prot_still_locked", 32'(locked), 32'd1);

    // Make MEM the last grant, then reset mid-transfer; pointer must clear
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_0007, 1'b0, 16'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
    doReset();
    checkOutput("post_reset_wr_en", 32'(wrEn), 32'd0);
    applyStimulus(1'b1, 5'd10, 32'hAAAA_0010, 1'b1, 5'd11, 32'hBBBB_0011, 1'b0, 16'd0);
    midCycle();
    checkOutput("post_reset_mem_first", 32'(memReady), 32'd1);
    checkOutput("post_reset_alu_wait", 32'(aluReady), 32'd0);
    tick();
    idle();
    checkOutput("post_reset_wr_addr", 32'(wrAddr), 32'd11);

    // Unlock window of 16 cycles
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 16'h0032);
    tick();
    for (int k = 1; k <= 17; k++) begin
      if (k == 1 || k == 16 || k == 17)
        applyStimulus(1'b1, 5'd31, 32'h3100_0000 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
      else
        idle();
      midCycle();
      checkOutput($sformatf("window%0d_locked", k), 32'(locked), (k <= 16) ? 32'd0 : 32'd1);
      tick();
      if (k == 1 || k == 16) begin
        checkOutput($sformatf("window%0d_wr_en", k), 32'(wrEn), 32'd1);
        checkOutput($sformatf("window%0d_wr_addr", k), 32'(wrAddr), 32'd31);
        checkOutput($sformatf("window%0d_wr_data", k), wrData, 32'h3100_0000 + 32'(k));
        checkOutput($sformatf("window%0d_violation", k), 32'(violation), 32'd0);
      end else if (k == 17) begin
        checkOutput("window17_wr_en", 32'(wrEn), 32'd0);
        checkOutput("window17_violation", 32'(violation), 32'd1);
      end
    end
    idle();

    // Wrong key while unlocked
    doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 16'h0032);
    tick();
    idle();
    checkOutput("wrongkey_unlocked", 32'(locked), 32'd0);
    tick();
    checkOutput("wrongkey_still_unlocked", 32'(locked), 32'd0);
    checkOutput("wrongkey_no_violation_yet", 32'(violation), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 16'h0033);
    tick();
    idle();
    checkOutput("wrongkey_relocked", 32'(locked), 32'd1);
    checkOutput("wrongkey_violation", 32'(violation), 32'd1);
    applyStimulus(1'b1, 5'd28, 32'h2828_2828, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0);
    tick();
    idle();
    checkOutput("wrongkey_prot28_dropped", 32'(wrEn), 32'd0);
    checkOutput("wrongkey_violation_held", 32'(violation), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Mutual exclusion of readies, checked on every falling edge
  always @(negedge clk) begin
    if (rstN && aluReady && memReady) begin
      failCount++;
      $display("[TB] FAIL both_ready: got alu=%0b mem=%0b, expected at most one (t=%0t)",
               aluReady, memReady, $time);
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and access guard in front of the 32x32 register file. It merges the ALU and memory write-back streams onto a single registered write port using valid/ready handshakes and round-robin arbitration on conflict. It also discards writes to x0 and enforces a key-gated lock on a protected register range (the secure key/context registers), raising a sticky violation flag on illegal access.

## Interface
- KEY, 16'h0032, unlock key compared against unlock_key
- PROT_LO, 5'd28, lowest protected register index (inclusive)
- PROT_HI, 5'd31, highest protected register index (inclusive)
- UNLOCK_WINDOW, 16, cycles the protected range stays writable after a valid unlock (1..255)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU write-back request
- alu_addr  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU request accepted this cycle (combinational)
- mem_valid  input  1  load write-back request
- mem_addr  input  5  load destination register
- mem_data  input  32  load data
- mem_ready  output  1  load request accepted this cycle (combinational)
- unlock_req  input  1  single-cycle unlock/relock strobe
- unlock_key  input  16  key presented with unlock_req
- wr_en  output  1  register-file write enable (registered)
- wr_addr  output  5  register-file write address (registered)
- wr_data  output  32  register-file write data (registered)
- locked  output  1  1 = protected range is write-locked
- violation  output  1  sticky security violation flag

## Operation
- Transfer: a request is accepted on a rising edge where valid && ready. Requesters hold valid, addr, and data stable until accepted. At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester gets ready.
  - Both valid: the requester not granted last gets ready.
  - The last-grant pointer updates only on an accepted transfer. It resets to "ALU last", so MEM wins the first conflict.
  - Neither valid: both readies are 0.
- Accepted request with addr == 0: consumed, no write issued (wr_en = 0 next cycle), no violation.
- Accepted request with addr in [PROT_LO, PROT_HI] while locked: consumed, dropped (wr_en = 0), violation set.
- All other accepted requests: next cycle wr_en = 1 and wr_addr/wr_data = the accepted addr/data. With no accepted request, or a dropped one, wr_en = 0 and wr_addr/wr_data hold their previous values.
- Lock FSM, 2 states, with an 8-bit counter cnt:
  - LOCKED (reset state, locked = 1).
    - unlock_req with unlock_key == KEY: go to UNLOCKED, load cnt = UNLOCK_WINDOW.
    - unlock_req with any other key: stay LOCKED, set violation.
  - UNLOCKED (locked = 0).
    - Each cycle cnt decrements. When cnt == 1 at an edge, go to LOCKED.
    - unlock_req with the correct key: reload cnt = UNLOCK_WINDOW (reload wins over decrement).
    - unlock_req with a wrong key: go to LOCKED immediately and set violation.
- Lock decisions use the FSM state before the edge. A protected write accepted in the same cycle as a valid unlock_req is still dropped with a violation. A protected write in the last UNLOCKED cycle (cnt == 1) is performed.
- violation clears only on rst_n.

## Timing
- Reset values (asynchronous, immediate on rst_n low): wr_en = 0, wr_addr = 0, wr_data = 0, locked = 1, violation = 0, cnt = 0, last-grant = ALU.
- Acceptance to write-port latency is 1 cycle. Throughput is 1 write per cycle, sustained.
- alu_ready and mem_ready are combinational from the valids and the last-grant pointer. They do not depend on addr or lock state.
- violation and locked change 1 cycle after the triggering edge's inputs, i.e. they are registered.
- UNLOCKED lasts exactly UNLOCK_WINDOW cycles after the unlock edge unless reloaded or relocked.
- rst_n asserted mid-transfer: pending grant and write are discarded. After release, the first conflict goes to MEM.

## Test plan
- Reset then single ALU write: alu_valid = 1, addr = 5, data = 32'hDEAD_BEEF. Required: alu_ready = 1 the same cycle; next cycle wr_en = 1, wr_addr = 5, wr_data = 32'hDEAD_BEEF; mem_ready = 0 throughout.
- Sustained conflict: both valid for 4 cycles, then alu_valid = 0 and mem_valid = 0 and requesters re-present. Required grant order MEM, ALU, MEM, ALU; wr_en high on 4 consecutive cycles; no cycle with both readies high.
- x0 drop: mem_valid with addr = 0, data = 32'h1234. Required: mem_ready = 1; next cycle wr_en = 0; violation = 0.
- Locked protected write: alu_valid with addr = 30 after reset. Required: accepted, wr_en = 0 next cycle, violation = 1 and held until rst_n.
- Unlock window: unlock_req with key 16'h0032, then protected writes to addr 31 on window cycles 1 and 16, and on cycle 17. Required: locked = 0 for exactly 16 cycles; the first two writes are performed; the cycle-17 write is dropped with violation = 1.
- Wrong key in UNLOCKED: unlock with key 16'h0032, then unlock_req with key 16'h0033 two cycles later. Required: locked = 1 and violation = 1 on the next cycle; a subsequent write to addr 28 is dropped.
